// File: rtl/fpdiv_scalar.sv
// fpdiv_scalar: multi-cycle IEEE 754 divider for fp16, fp32 and fp64.
// Uses one radix-2 restoring step per cycle; rounding and the exception
// flags are fully IEEE 754-2008, with tininess detected after rounding.
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   start_valid_i    request valid; start_ready_o is high only when idle
//   flush_i          abort the current operation and return to idle
//   fp_format_i      0=fp16, 1=fp32, 2/3=fp64
//   opa_i, opb_i     dividend/divisor, right-aligned
//   rm_i             0=RNE 1=RTZ 2=RDN 3=RUP 4=RMM (5-7 act as RNE)
//   finish_valid_o   result valid; held until finish_ready_i
//   fpdiv_res_o      quotient, right-aligned, upper bits zero
//   fflags_o         {NV,DZ,OF,UF,NX}
module fpdiv_scalar (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid_i,
    output logic        start_ready_o,
    input  logic        flush_i,
    input  logic [1:0]  fp_format_i,
    input  logic [63:0] opa_i,
    input  logic [63:0] opb_i,
    input  logic [2:0]  rm_i,
    output logic        finish_valid_o,
    input  logic        finish_ready_i,
    output logic [63:0] fpdiv_res_o,
    output logic [4:0]  fflags_o
);

    typedef enum logic [2:0] {IDLE, PRE, ITER, POST, DONE} state_t;

    // Fraction is left-aligned to bit 51 for every format, so the whole
    // datapath works at fp64 width and only rounding depends on the format.
    typedef struct packed {
        logic        sign;
        logic        exp_max;
        logic        exp_zero;
        logic        man_zero;
        logic        quiet;
        logic [10:0] exp;
        logic [51:0] man;
    } fields_t;

    function automatic fields_t unpack(input logic [1:0] fmt, input logic [63:0] x);
        fields_t f;
        case (fmt)
            2'd0: begin
                f.sign = x[15]; f.exp = {6'd0, x[14:10]}; f.man = {x[9:0], 42'd0}; f.exp_max = &x[14:10];
            end
            2'd1: begin
                f.sign = x[31]; f.exp = {3'd0, x[30:23]}; f.man = {x[22:0], 29'd0}; f.exp_max = &x[30:23];
            end
            default: begin
                f.sign = x[63]; f.exp = x[62:52]; f.man = x[51:0]; f.exp_max = &x[62:52];
            end
        endcase
        f.exp_zero = (f.exp == 11'd0);
        f.man_zero = (f.man == 52'd0);
        f.quiet    = f.man[51];
        return f;
    endfunction

    function automatic logic [5:0] lzc53(input logic [52:0] v);
        logic [5:0] n;
        logic       found;
        n = 6'd0;
        found = 1'b0;
        for (int i = 52; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 6'd1;
            end
        end
        return n;
    endfunction

    function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                       input logic lsb, input logic g, input logic st);
        case (rm)
            3'd1:    return 1'b0;
            3'd2:    return sign & (g | st);
            3'd3:    return ~sign & (g | st);
            3'd4:    return g;
            default: return g & (st | lsb);
        endcase
    endfunction

    function automatic logic [63:0] pack(input logic [1:0] fmt, input logic sign,
                                         input logic [10:0] ex, input logic [51:0] fr);
        case (fmt)
            2'd0:    return {48'd0, sign, ex[4:0], fr[9:0]};
            2'd1:    return {32'd0, sign, ex[7:0], fr[22:0]};
            default: return {sign, ex, fr};
        endcase
    endfunction

    state_t state, state_nxt;

    logic [1:0]  fmt_q;
    logic [2:0]  rm_q;
    logic [63:0] opa_q, opb_q, res_q;
    logic [4:0]  flags_q;
    logic        sign_q;
    logic signed [13:0] exp_q;
    logic [52:0] sigb_q;
    logic [53:0] rem_q;
    logic [54:0] quo_q;
    logic [5:0]  cnt_q;

    logic [5:0]  prec, nbits;
    logic signed [13:0] bias, emin, emax;
    fields_t     fa, fb;
    logic [52:0] siga_raw, sigb_raw, siga_n, sigb_n;
    logic [5:0]  lza, lzb;
    logic signed [13:0] ea, eb;
    logic        a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan;
    logic        special;
    logic [63:0] spec_res, cnan;
    logic [4:0]  spec_flags;
    logic        rem_ge;
    logic [52:0] rem_sub;

    always_comb begin
        case (fmt_q)
            2'd0:    begin prec = 6'd11; bias = 14'sd15;   cnan = 64'h7E00; end
            2'd1:    begin prec = 6'd24; bias = 14'sd127;  cnan = 64'h7FC00000; end
            default: begin prec = 6'd53; bias = 14'sd1023; cnan = 64'h7FF8000000000000; end
        endcase
    end

    assign nbits = prec + 6'd2;
    assign emin  = 14'sd1 - bias;
    assign emax  = bias;

    // Unpack both operands and bring subnormals to a leading one at bit 52.
    assign fa       = unpack(fmt_q, opa_q);
    assign fb       = unpack(fmt_q, opb_q);
    assign siga_raw = {~fa.exp_zero, fa.man};
    assign sigb_raw = {~fb.exp_zero, fb.man};
    assign lza      = lzc53(siga_raw);
    assign lzb      = lzc53(sigb_raw);
    assign siga_n   = siga_raw << lza;
    assign sigb_n   = sigb_raw << lzb;
    assign ea = $signed({3'd0, (fa.exp_zero ? 11'd1 : fa.exp)}) - bias - $signed({8'd0, lza});
    assign eb = $signed({3'd0, (fb.exp_zero ? 11'd1 : fb.exp)}) - bias - $signed({8'd0, lzb});

    assign a_zero = fa.exp_zero & fa.man_zero;
    assign a_inf  = fa.exp_max & fa.man_zero;
    assign a_nan  = fa.exp_max & ~fa.man_zero;
    assign a_snan = a_nan & ~fa.quiet;
    assign b_zero = fb.exp_zero & fb.man_zero;
    assign b_inf  = fb.exp_max & fb.man_zero;
    assign b_nan  = fb.exp_max & ~fb.man_zero;
    assign b_snan = b_nan & ~fb.quiet;

    // Priority matters: invalid cases first, then quiet NaN propagation,
    // then infinities and zeros.
    always_comb begin
        special    = 1'b1;
        spec_res   = 64'd0;
        spec_flags = 5'd0;
        if (a_snan | b_snan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            spec_res = cnan; spec_flags = 5'b10000;
        end else if (a_nan | b_nan) begin
            spec_res = cnan;
        end else if (a_inf) begin
            spec_res = pack(fmt_q, fa.sign ^ fb.sign, 11'h7FF, 52'd0);
        end else if (b_zero) begin
            spec_res = pack(fmt_q, fa.sign ^ fb.sign, 11'h7FF, 52'd0);
            spec_flags = 5'b01000;
        end else if (b_inf | a_zero) begin
            spec_res = pack(fmt_q, fa.sign ^ fb.sign, 11'd0, 52'd0);
        end else begin
            special = 1'b0;
        end
    end

    // The 53-bit difference is exact because it is only used when rem >= divisor.
    assign rem_ge  = (rem_q >= {1'b0, sigb_q});
    assign rem_sub = rem_q[52:0] - sigb_q;

    logic [54:0] qa, m, md, lowmask, ones_p, kept_n, kept, kr;
    logic signed [13:0] e, d, ed, er, biased;
    logic [5:0]  shamt, dcl;
    logic        rem_st, inc_n, tiny, lost, sticky, inexact, is_norm, ovf, to_inf;
    logic [63:0] post_res;
    logic [4:0]  post_flags;

    // Post-processing: normalize the quotient, denormalize below emin, round
    // at the format's precision and pack. Tininess uses a second rounding of
    // the still-normalized value, as if the exponent range were unbounded.
    always_comb begin
        qa = quo_q << (6'd55 - nbits);
        if (qa[54]) begin
            m = qa;
            e = exp_q;
        end else begin
            m = {qa[53:0], 1'b0};
            e = exp_q - 14'sd1;
        end
        rem_st  = |rem_q;
        shamt   = 6'd55 - prec;
        lowmask = (55'd1 << (shamt - 6'd1)) - 55'd1;
        ones_p  = (55'd1 << prec) - 55'd1;

        kept_n = m >> shamt;
        inc_n  = round_inc(rm_q, sign_q, kept_n[0], m[shamt - 6'd1], (|(m & lowmask)) | rem_st);
        tiny   = (e < emin) && !(inc_n && (kept_n == ones_p) && (e == emin - 14'sd1));

        if (e < emin) begin
            d    = emin - e;
            dcl  = (d > 14'sd63) ? 6'd63 : d[5:0];
            md   = m >> dcl;
            lost = |(m & ((55'd1 << dcl) - 55'd1));
            ed   = emin;
        end else begin
            d    = 14'sd0;
            dcl  = 6'd0;
            md   = m;
            lost = 1'b0;
            ed   = e;
        end

        kept    = md >> shamt;
        sticky  = (|(md & lowmask)) | rem_st | lost;
        inexact = md[shamt - 6'd1] | sticky;
        kr      = kept + {54'd0, round_inc(rm_q, sign_q, kept[0], md[shamt - 6'd1], sticky)};
        if (kr == (55'd1 << prec)) begin
            kr = kr >> 1;
            er = ed + 14'sd1;
        end else begin
            er = ed;
        end
        is_norm = kr[prec - 6'd1];
        ovf     = is_norm && (er > emax);
        biased  = is_norm ? (er + bias) : 14'sd0;
        to_inf  = (rm_q == 3'd0) || (rm_q == 3'd4) || ((rm_q == 3'd2) && sign_q) ||
                  ((rm_q == 3'd3) && !sign_q);

        if (ovf) begin
            post_res   = to_inf ? pack(fmt_q, sign_q, 11'h7FF, 52'd0)
                                : pack(fmt_q, sign_q, 11'h7FE, {52{1'b1}});
            post_flags = 5'b00101;
        end else begin
            post_res   = pack(fmt_q, sign_q, biased[10:0], kr[51:0] & ones_p[52:1]);
            post_flags = {3'b000, tiny & inexact, inexact};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        start_ready_o  = 1'b0;
        finish_valid_o = 1'b0;
        case (state)
            IDLE: begin
                start_ready_o = 1'b1;
                if (start_valid_i) state_nxt = PRE;
            end
            PRE:  state_nxt = special ? DONE : ITER;
            ITER: if (cnt_q == 6'd0) state_nxt = POST;
            POST: state_nxt = DONE;
            DONE: begin
                finish_valid_o = 1'b1;
                if (finish_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fmt_q   <= 2'd0;
            rm_q    <= 3'd0;
            opa_q   <= 64'd0;
            opb_q   <= 64'd0;
            res_q   <= 64'd0;
            flags_q <= 5'd0;
            sign_q  <= 1'b0;
            exp_q   <= 14'sd0;
            sigb_q  <= 53'd0;
            rem_q   <= 54'd0;
            quo_q   <= 55'd0;
            cnt_q   <= 6'd0;
        end else if (!flush_i) begin
            case (state)
                IDLE: if (start_valid_i) begin
                    fmt_q <= (fp_format_i == 2'd3) ? 2'd2 : fp_format_i;
                    rm_q  <= (rm_i > 3'd4) ? 3'd0 : rm_i;
                    opa_q <= opa_i;
                    opb_q <= opb_i;
                end
                PRE: begin
                    sign_q  <= fa.sign ^ fb.sign;
                    exp_q   <= ea - eb;
                    rem_q   <= {1'b0, siga_n};
                    sigb_q  <= sigb_n;
                    quo_q   <= 55'd0;
                    cnt_q   <= nbits - 6'd1;
                    res_q   <= spec_res;
                    flags_q <= spec_flags;
                end
                ITER: begin
                    quo_q <= {quo_q[53:0], rem_ge};
                    rem_q <= rem_ge ? {rem_sub, 1'b0} : {rem_q[52:0], 1'b0};
                    cnt_q <= cnt_q - 6'd1;
                end
                POST: begin
                    res_q   <= post_res;
                    flags_q <= post_flags;
                end
                default: ;
            endcase
        end
    end

    assign fpdiv_res_o = res_q;
    assign fflags_o    = flags_q;

endmodule

// File: tb/tb_fpdiv_scalar.sv
// tb_fpdiv_scalar: directed-vector bench for fpdiv_scalar with hand-computed
// quotients, flags and latencies, plus hold, flush and reset sequences.
module tb_fpdiv_scalar;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid_i;
    logic        start_ready_o;
    logic        flush_i;
    logic [1:0]  fp_format_i;
    logic [63:0] opa_i;
    logic [63:0] opb_i;
    logic [2:0]  rm_i;
    logic        finish_valid_o;
    logic        finish_ready_i;
    logic [63:0] fpdiv_res_o;
    logic [4:0]  fflags_o;

    int err_count   = 0;
    int check_count = 0;

    fpdiv_scalar dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_valid_i  (start_valid_i),
        .start_ready_o  (start_ready_o),
        .flush_i        (flush_i),
        .fp_format_i    (fp_format_i),
        .opa_i          (opa_i),
        .opb_i          (opb_i),
        .rm_i           (rm_i),
        .finish_valid_o (finish_valid_o),
        .finish_ready_i (finish_ready_i),
        .fpdiv_res_o    (fpdiv_res_o),
        .fflags_o       (fflags_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Handshake one request, then scramble every input to show it is ignored.
    task automatic startOp(input logic [1:0] fmt, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] rm);
        fp_format_i   = fmt;
        opa_i         = a;
        opb_i         = b;
        rm_i          = rm;
        start_valid_i = 1'b1;
        @(posedge clk); #1;
        start_valid_i = 1'b0;
        opa_i         = {$urandom, $urandom};
        opb_i         = {$urandom, $urandom};
        rm_i          = rm ^ 3'd1;
        fp_format_i   = ~fmt;
    endtask

    // Cycle 0 is the handshake cycle; returns the cycle in which finish_valid_o is seen.
    task automatic applyStimulus(input logic [1:0] fmt, input logic [63:0] a, input logic [63:0] b,
                                 input logic [2:0] rm, output int cycles);
        startOp(fmt, a, b, rm);
        cycles = 1;
        while (!finish_valid_o && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic ackResult(input string tag);
        finish_ready_i = 1'b1;
        @(posedge clk); #1;
        finish_ready_i = 1'b0;
        checkOutput({tag, " idle after ack"}, 64'(start_ready_o), 64'd1);
        checkOutput({tag, " valid low after ack"}, 64'(finish_valid_o), 64'd0);
    endtask

    task automatic runVector(input string tag, input logic [1:0] fmt, input logic [63:0] a,
                             input logic [63:0] b, input logic [2:0] rm, input logic [63:0] exp_res,
                             input logic [4:0] exp_flags, input int exp_cycles);
        int cyc;
        checkOutput({tag, " ready"}, 64'(start_ready_o), 64'd1);
        applyStimulus(fmt, a, b, rm, cyc);
        checkOutput({tag, " valid"}, 64'(finish_valid_o), 64'd1);
        checkOutput({tag, " res"}, fpdiv_res_o, exp_res);
        checkOutput({tag, " flags"}, 64'(fflags_o), 64'(exp_flags));
        checkOutput({tag, " latency"}, 64'(cyc), 64'(exp_cycles));
        ackResult(tag);
    endtask

    initial begin
        int cyc;
        int seen;
        rst_n          = 1'b0;
        start_valid_i  = 1'b0;
        flush_i        = 1'b0;
        finish_ready_i = 1'b0;
        fp_format_i    = 2'd0;
        opa_i          = 64'd0;
        opb_i          = 64'd0;
        rm_i           = 3'd0;
        repeat (2) @(posedge clk); #1;
        checkOutput("reset ready", 64'(start_ready_o), 64'd1);
        checkOutput("reset valid", 64'(finish_valid_o), 64'd0);
        checkOutput("reset res", fpdiv_res_o, 64'd0);
        checkOutput("reset flags", 64'(fflags_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        runVector("fp32 1/2 rne",   2'd1, 64'h3F800000, 64'h40000000, 3'd0, 64'h3F000000, 5'h00, 29);
        runVector("fp32 1/3 rne",   2'd1, 64'h3F800000, 64'h40400000, 3'd0, 64'h3EAAAAAB, 5'h01, 29);
        runVector("fp32 1/3 rtz",   2'd1, 64'h3F800000, 64'h40400000, 3'd1, 64'h3EAAAAAA, 5'h01, 29);
        runVector("fp32 1/3 rdn",   2'd1, 64'h3F800000, 64'h40400000, 3'd2, 64'h3EAAAAAA, 5'h01, 29);
        runVector("fp32 1/3 rup",   2'd1, 64'h3F800000, 64'h40400000, 3'd3, 64'h3EAAAAAB, 5'h01, 29);
        runVector("fp32 1/3 rmm",   2'd1, 64'h3F800000, 64'h40400000, 3'd4, 64'h3EAAAAAB, 5'h01, 29);
        runVector("fp32 1/3 rm7",   2'd1, 64'h3F800000, 64'h40400000, 3'd7, 64'h3EAAAAAB, 5'h01, 29);
        runVector("fp16 1/0",       2'd0, 64'h3C00, 64'h0000, 3'd0, 64'h7C00, 5'h08, 2);
        runVector("fp64 0/0",       2'd2, 64'h0, 64'h0, 3'd0, 64'h7FF8000000000000, 5'h10, 2);
        runVector("fp16 ovf rne",   2'd0, 64'h7BFF, 64'h3800, 3'd0, 64'h7C00, 5'h05, 16);
        runVector("fp16 ovf rtz",   2'd0, 64'h7BFF, 64'h3800, 3'd1, 64'h7BFF, 5'h05, 16);
        runVector("fp16 -ovf rdn",  2'd0, 64'hFBFF, 64'h3800, 3'd2, 64'hFC00, 5'h05, 16);
        runVector("fp16 -ovf rup",  2'd0, 64'hFBFF, 64'h3800, 3'd3, 64'hFBFF, 5'h05, 16);
        runVector("fp64 exact sub", 2'd2, 64'h0010000000000000, 64'h4000000000000000, 3'd0,
                  64'h0008000000000000, 5'h00, 58);
        runVector("fp32 uf rne",    2'd1, 64'h00800000, 64'h40400000, 3'd0, 64'h002AAAAB, 5'h03, 29);
        runVector("fp16 sub/1",     2'd0, 64'h0001, 64'h3C00, 3'd0, 64'h0001, 5'h00, 16);
        runVector("fp16 tie to 0",  2'd0, 64'h0001, 64'h4000, 3'd0, 64'h0000, 5'h03, 16);
        runVector("fp16 tie rup",   2'd0, 64'h0001, 64'h4000, 3'd3, 64'h0001, 5'h03, 16);
        runVector("fp32 -6/2",      2'd1, 64'hC0C00000, 64'h40000000, 3'd0, 64'hC0400000, 5'h00, 29);
        runVector("fp32 snan",      2'd1, 64'h7F800001, 64'h3F800000, 3'd0, 64'h7FC00000, 5'h10, 2);
        runVector("fp32 qnan",      2'd1, 64'h7FC00000, 64'h3F800000, 3'd0, 64'h7FC00000, 5'h00, 2);
        runVector("fp32 inf/2",     2'd1, 64'h7F800000, 64'h40000000, 3'd0, 64'h7F800000, 5'h00, 2);
        runVector("fp32 2/inf",     2'd1, 64'h40000000, 64'h7F800000, 3'd0, 64'h00000000, 5'h00, 2);
        runVector("fp32 -0/5",      2'd1, 64'h80000000, 64'h40A00000, 3'd0, 64'h80000000, 5'h00, 2);
        runVector("fmt3 as fp64",   2'd3, 64'h3FF0000000000000, 64'h4000000000000000, 3'd0,
                  64'h3FE0000000000000, 5'h00, 58);
        runVector("fp16 upper junk", 2'd0, 64'hDEADBEEF00004000, 64'hFFFFFFFFFFFF3C00, 3'd0,
                  64'h0000000000004000, 5'h00, 16);

        // Result must stay put while the consumer stalls, and no new start is taken.
        applyStimulus(2'd1, 64'h3F800000, 64'h40000000, 3'd0, cyc);
        start_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("hold valid", 64'(finish_valid_o), 64'd1);
            checkOutput("hold res", fpdiv_res_o, 64'h3F000000);
            checkOutput("hold flags", 64'(fflags_o), 64'd0);
            checkOutput("hold ready", 64'(start_ready_o), 64'd0);
        end
        start_valid_i = 1'b0;
        ackResult("hold");

        // Flush in the middle of the iterations.
        startOp(2'd1, 64'h3F800000, 64'h40400000, 3'd0);
        repeat (5) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        checkOutput("flush ready", 64'(start_ready_o), 64'd1);
        checkOutput("flush valid", 64'(finish_valid_o), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (finish_valid_o) seen++;
        end
        checkOutput("flush no result", 64'(seen), 64'd0);

        // Flush beats a start handshake in the same cycle.
        fp_format_i   = 2'd1;
        opa_i         = 64'h3F800000;
        opb_i         = 64'h40000000;
        start_valid_i = 1'b1;
        flush_i       = 1'b1;
        @(posedge clk); #1;
        start_valid_i = 1'b0;
        flush_i       = 1'b0;
        checkOutput("flush vs start ready", 64'(start_ready_o), 64'd1);
        seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (finish_valid_o) seen++;
        end
        checkOutput("flush vs start no result", 64'(seen), 64'd0);

        // Reset in the middle of the iterations.
        startOp(2'd1, 64'h3F800000, 64'h40400000, 3'd0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("midreset ready", 64'(start_ready_o), 64'd1);
        checkOutput("midreset valid", 64'(finish_valid_o), 64'd0);
        checkOutput("midreset res", fpdiv_res_o, 64'd0);
        checkOutput("midreset flags", 64'(fflags_o), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (finish_valid_o) seen++;
        end
        checkOutput("midreset no result", 64'(seen), 64'd0);

        runVector("after reset", 2'd1, 64'h3F800000, 64'h40400000, 3'd1, 64'h3EAAAAAA, 5'h01, 29);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/fpdiv_scalar.md
FPDIV_SCALAR -- requirements
Module: fpdiv_scalar

Interface
REQ-001 SHALL have no parameters; fp16, fp32 and fp64 support is fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start_valid_i  in  1  request valid.
REQ-005 start_ready_o  out  1  divider idle, can accept a request.
REQ-006 flush_i  in  1  abort current operation.
REQ-007 fp_format_i  in  2  operand format: 0=fp16, 1=fp32, 2=fp64; 3 is reserved and treated as fp64.
REQ-008 opa_i  in  64  dividend, right-aligned in the low bits; unused upper bits are ignored.
REQ-009 opb_i  in  64  divisor, same alignment as opa_i.
REQ-010 rm_i  in  3  rounding mode: 0=RNE, 1=RTZ, 2=RDN, 3=RUP, 4=RMM; 5-7 are treated as RNE.
REQ-011 finish_valid_o  out  1  result valid.
REQ-012 finish_ready_i  in  1  consumer accepts the result.
REQ-013 fpdiv_res_o  out  64  quotient, right-aligned; unused upper bits are 0.
REQ-014 fflags_o  out  5  {NV,DZ,OF,UF,NX}, bits 4..0.

Function
REQ-015 SHALL be an FSM with states IDLE, PRE, ITER, POST, DONE.
REQ-016 start_ready_o SHALL be 1 only in IDLE.
REQ-017 Start handshake: start_valid_i & start_ready_o at a clock edge; operands, fp_format_i and rm_i SHALL be registered then and FSM goes to PRE.
REQ-018 Inputs SHALL be ignored outside the start handshake; changing them mid-operation has no effect.
REQ-019 PRE (1 cycle):
- unpack operands; normalize subnormals with a leading-zero count;
- compute exponent difference;
- detect special cases (REQ-024); a special case goes directly to DONE.
REQ-020 ITER: radix-2 restoring division, one quotient bit per cycle.
- Bit counts: 13 (fp16), 26 (fp32), 55 (fp64), i.e. significand+2.
- sticky = OR of the final remainder.
REQ-021 POST (1 cycle):
- normalize the quotient;
- denormalize if the exponent is below the minimum;
- round per the registered rm; pack; set flags;
- go to DONE.
REQ-022 Fixed latency from start handshake to finish_valid_o rising: 3+N cycles, where N is from REQ-020. Special cases take 2 cycles.
REQ-023 In DONE:
- finish_valid_o=1; fpdiv_res_o/fflags_o stable;
- on finish_ready_i go to IDLE next cycle;
- a new start is accepted only from IDLE (no same-cycle overlap).
REQ-024 Special cases:
- either operand sNaN, 0/0, or inf/inf -> canonical NaN, NV;
- any qNaN -> canonical NaN, no flags;
- finite nonzero / 0 -> signed inf, DZ;
- inf/finite -> signed inf;
- finite/inf or 0/nonzero -> signed zero;
- flags are 0 unless stated.
REQ-025 Canonical NaN: 0x7E00 / 0x7FC00000 / 0x7FF8000000000000.
REQ-026 Sign SHALL be signa XOR signb, including for zero and inf results.
REQ-027 Rounding SHALL follow IEEE 754-2008.
- Overflow: RNE/RMM give inf; RTZ gives max finite; RDN gives max finite if positive, else -inf; RUP gives inf if positive, else max finite.
- Overflow sets OF|NX.
REQ-028 Underflow:
- tininess detected after rounding (RISC-V);
- UF only when the result is tiny and inexact;
- NX whenever the rounded result differs from the exact quotient.
REQ-029 flush_i=1 SHALL force IDLE on the next edge from any state, with finish_valid_o=0. It has priority over handshakes; the aborted result is never presented.
REQ-030 When finish_valid_o=0, fpdiv_res_o and fflags_o are don't-care.

Reset
REQ-031 With rst_n=0 at an edge:
- state goes to IDLE; finish_valid_o=0, start_ready_o=1 after the edge;
- fpdiv_res_o=0, fflags_o=0;
- any in-flight operation is discarded.
REQ-032 Reset SHALL have priority over flush_i and handshakes.

Verification
REQ-033 fp32 0x3F800000/0x40000000, RNE -> 0x3F000000, flags 00000, finish_valid_o 29 cycles after the handshake.
REQ-034 fp32 0x3F800000/0x40400000:
- RNE -> 0x3EAAAAAB, flags 00001;
- RTZ -> 0x3EAAAAAA, flags 00001.
REQ-035 Special cases:
- fp16 0x3C00/0x0000 -> 0x7C00, flags 01000;
- fp64 0/0 -> 0x7FF8000000000000, flags 10000;
- both in 2 cycles.
REQ-036 fp16 0x7BFF/0x3800:
- RNE -> 0x7C00, flags 00101;
- RTZ -> 0x7BFF, flags 00101.
REQ-037 fp64 0x0010000000000000/0x4000000000000000, RNE -> 0x0008000000000000 (exact subnormal), flags 00000.
REQ-038 Control sequences:
- hold finish_ready_i=0 for 5 cycles: outputs stay stable, start_ready_o=0;
- flush_i mid-ITER: IDLE next cycle, no finish_valid_o;
- rst_n=0 mid-ITER: same.
